// File: rtl/fifo_pkg.sv
//------------------------------------------------------------------------------
// Module  : fifo_pkg
// Brief   : Shared helpers for the dual-clock FIFO pointer controllers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  // Working width for the converters. Narrower pointers are zero-extended on
  // the way in, which leaves both conversions correct for any width up to this.
  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ptr_sync.sv
//------------------------------------------------------------------------------
// Module  : ptr_sync
// Brief   : N-stage flop synchroniser for a Gray-coded pointer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  localparam int PIPE_W = WIDTH * STAGES;

  logic [PIPE_W-1:0] pipe_q;
  logic [PIPE_W-1:0] pipe_d;

  // New sample enters at the low end; the oldest stage is the output.
  assign pipe_d = {pipe_q[PIPE_W-WIDTH-1:0], async_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign sync_o = pipe_q[PIPE_W-1 -: WIDTH];

endmodule

`default_nettype wire

// File: rtl/wr_full_ctrl.sv
//------------------------------------------------------------------------------
// Module  : wr_full_ctrl
// Brief   : Write-side pointer, full/almost-full, level and overflow logic.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int AFULL_THRESH = (2**ADDR_WIDTH) - 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rstn,
  input  logic                  wr_en,
  input  logic                  ovf_clr,
  input  logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_ram_we,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_overflow
);

  localparam int              PTR_W   = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AFULL_L = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] wr_bin_q,   wr_bin_d;
  logic [PTR_W-1:0] wr_gray_q,  wr_gray_d;
  logic             full_q,     full_d;
  logic             afull_q,    afull_d;
  logic [PTR_W-1:0] level_q,    level_d;
  logic             ovf_q,      ovf_d;

  logic             w_push;
  logic [PTR_W-1:0] w_rd_gray_s;
  logic [PTR_W-1:0] w_rd_bin_s;
  logic [PTR_W-1:0] w_full_gray;

  ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk     (wr_clk),
    .rst_n   (wr_rstn),
    .async_i (rd_ptr),
    .sync_o  (w_rd_gray_s)
  );

  assign w_push     = wr_en & ~full_q;
  assign w_rd_bin_s = PTR_W'(gray2bin(ptr_word_t'(w_rd_gray_s)));

  // Full when the write pointer is exactly one lap ahead: in Gray that is the
  // read pointer with its two top bits inverted.
  assign w_full_gray = {~w_rd_gray_s[PTR_W-1:PTR_W-2], w_rd_gray_s[PTR_W-3:0]};

  always_comb begin
    wr_bin_d  = wr_bin_q + PTR_W'(w_push);
    wr_gray_d = PTR_W'(bin2gray(ptr_word_t'(wr_bin_d)));
    level_d   = wr_bin_d - w_rd_bin_s;
    full_d    = (wr_gray_d == w_full_gray);
    afull_d   = (level_d >= AFULL_L);
    ovf_d     = ovf_q;
    if (wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wr_ptr         = wr_gray_q;
  assign wr_addr        = wr_bin_q[ADDR_WIDTH-1:0];
  assign wr_ram_we      = w_push;
  assign wr_full        = full_q;
  assign wr_almost_full = afull_q;
  assign wr_level       = level_q;
  assign wr_overflow    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_wr_full_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_wr_full_ctrl
// Brief   : Scoreboard bench for wr_full_ctrl (ADDR_WIDTH=3, AFULL=6, 2 sync stages).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wr_full_ctrl;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] rd_ptr = '0;
  logic [3:0] wr_ptr;
  logic [2:0] wr_addr;
  logic       wr_ram_we;
  logic       wr_full;
  logic       wr_almost_full;
  logic [3:0] wr_level;
  logic       wr_overflow;

  wr_full_ctrl #(
    .ADDR_WIDTH   (3),
    .AFULL_THRESH (6),
    .SYNC_STAGES  (2)
  ) dut (
    .wr_clk         (clk),
    .wr_rstn        (rstn),
    .wr_en          (wr_en),
    .ovf_clr        (ovf_clr),
    .rd_ptr         (rd_ptr),
    .wr_ptr         (wr_ptr),
    .wr_addr        (wr_addr),
    .wr_ram_we      (wr_ram_we),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_level       (wr_level),
    .wr_overflow    (wr_overflow)
  );

  always #5 if (clk_run) clk = ~clk;

  typedef struct {
    logic [3:0] ptr;
    logic [2:0] addr;
    logic       full;
    logic       afull;
    logic [3:0] lvl;
    logic       ovf;
    int         flips;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Occupancy model: total accepted writes vs read position as seen after the
  // synchroniser delay.
  int   m_wr   = 0;
  int   m_s1   = 0;
  int   m_s2   = 0;
  logic m_full = 1'b0;
  logic m_ovf  = 1'b0;
  logic [3:0] prev_ptr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_wr = 0; m_s1 = 0; m_s2 = 0;
    m_full = 1'b0; m_ovf = 1'b0; prev_ptr = '0;
    sb.delete();
  endtask

  task automatic step(input logic en, input logic clr, input int rb);
    exp_t e;
    int   vis;
    int   lvl;
    logic push;
    exp_t got;
    @(negedge clk);
    wr_en   = en;
    ovf_clr = clr;
    rd_ptr  = to_gray(rb);
    #1;
    push = en && !m_full;
    chk("ram_we", 32'(wr_ram_we), 32'(push));
    chk("addr_now", 32'(wr_addr), 32'(m_wr % 8));
    vis  = m_s2;
    m_s2 = m_s1;
    m_s1 = rb;
    if (push) m_wr = (m_wr + 1) % 16;
    lvl = ((m_wr - vis) % 16 + 16) % 16;
    e.ptr   = to_gray(m_wr);
    e.addr  = 3'(m_wr % 8);
    e.full  = (lvl == 8);
    e.afull = (lvl >= 6);
    e.lvl   = 4'(lvl);
    if (en && m_full) m_ovf = 1'b1;
    else if (clr)     m_ovf = 1'b0;
    e.ovf   = m_ovf;
    e.flips = push ? 1 : 0;
    m_full  = e.full;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("wr_ptr",  32'(wr_ptr),         32'(got.ptr));
    chk("wr_addr", 32'(wr_addr),        32'(got.addr));
    chk("full",    32'(wr_full),        32'(got.full));
    chk("afull",   32'(wr_almost_full), 32'(got.afull));
    chk("level",   32'(wr_level),       32'(got.lvl));
    chk("ovf",     32'(wr_overflow),    32'(got.ovf));
    chk("gray_step", 32'($countones(wr_ptr ^ prev_ptr)), 32'(got.flips));
    prev_ptr = wr_ptr;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ptr"},   32'(wr_ptr),         32'd0);
    chk({tag, "_addr"},  32'(wr_addr),        32'd0);
    chk({tag, "_full"},  32'(wr_full),        32'd0);
    chk({tag, "_afull"}, 32'(wr_almost_full), 32'd0);
    chk({tag, "_level"}, 32'(wr_level),       32'd0);
    chk({tag, "_ovf"},   32'(wr_overflow),    32'd0);
  endtask

  initial begin
    int rb;
    // 1: reset and idle
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    repeat (2) step(1'b0, 1'b0, 0);

    // 2: fill with no reads
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 0);
      chk("afull_after_n", 32'(wr_almost_full), 32'(i >= 5));
    end
    chk("full_at_8", 32'(wr_full), 32'd1);
    chk("ptr_at_8", 32'(wr_ptr), 32'b1100);
    chk("level_at_8", 32'(wr_level), 32'd8);

    // 3: overflow behaviour while full
    step(1'b1, 1'b0, 0);
    chk("ptr_held", 32'(wr_ptr), 32'b1100);
    step(1'b0, 1'b0, 0);
    chk("ovf_sticky", 32'(wr_overflow), 32'd1);
    step(1'b0, 1'b1, 0);
    chk("ovf_cleared", 32'(wr_overflow), 32'd0);
    step(1'b1, 1'b1, 0);
    chk("ovf_set_wins", 32'(wr_overflow), 32'd1);

    // 4: one remote read; full drops on the third edge
    step(1'b0, 1'b0, 1);
    chk("full_edge1", 32'(wr_full), 32'd1);
    step(1'b0, 1'b0, 1);
    chk("full_edge2", 32'(wr_full), 32'd1);
    step(1'b0, 1'b0, 1);
    chk("full_edge3", 32'(wr_full), 32'd0);
    chk("level_edge3", 32'(wr_level), 32'd7);
    chk("afull_edge3", 32'(wr_almost_full), 32'd1);

    // Restart from reset for the streaming test
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    rd_ptr = '0;
    model_reset();

    // 5: streaming with the reader close behind
    for (int i = 0; i < 16; i++) begin
      rb = (i == 0) ? 0 : i - 1;
      step(1'b1, 1'b0, rb);
      chk("stream_no_full", 32'(wr_full), 32'd0);
    end
    chk("stream_ptr_wrap", 32'(wr_ptr), 32'd0);
    repeat (3) step(1'b0, 1'b0, 16 % 16);

    // 6: async reset with clock stopped at level 5
    @(negedge clk);
    rstn = 1'b0;
    #1;
    @(negedge clk);
    rstn = 1'b1;
    rd_ptr = '0;
    model_reset();
    repeat (5) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    chk("level_before_rst", 32'(wr_level), 32'd5);
    @(negedge clk);
    clk_run = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    chk("async_rst_we", 32'(wr_ram_we), 32'd0);
    #10;
    rstn = 1'b1;
    model_reset();
    #2;
    clk_run = 1'b1;
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    chk("first_after_rst_ptr", 32'(wr_ptr), 32'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
